// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB/APB codes and bridge FSM encoding
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_e;

endpackage

// File: rtl/apb_slave_mux.sv
// rtl/apb_slave_mux.sv - one-hot APB select and per-slave response select
module apb_slave_mux
  import ahb_apb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 2
) (
  input  logic [IDX_W-1:0]          idx,
  input  logic                      sel_en,
  input  logic [NUM_SLV*DATA_W-1:0] prdata_bus,
  input  logic [NUM_SLV-1:0]        pready_bus,
  input  logic [NUM_SLV-1:0]        pslverr_bus,
  output logic [NUM_SLV-1:0]        psel,
  output logic [DATA_W-1:0]         prdata,
  output logic                      pready,
  output logic                      pslverr
);

  // Only the indexed slave is selected or listened to; out-of-range indices match nothing
  always_comb begin
    psel    = '0;
    prdata  = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == IDX_W'(i)) begin
        psel[i] = sel_en;
        prdata  = prdata_bus[i*DATA_W +: DATA_W];
        pready  = pready_bus[i];
        pslverr = pslverr_bus[i];
      end
    end
  end

endmodule

// File: rtl/ahb2apb_mux_bridge.sv
// rtl/ahb2apb_mux_bridge.sv - AHB-Lite slave to multi-slave APB4 master bridge
module ahb2apb_mux_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int SLV_SEL_LSB = 12,
  parameter int TIMEOUT     = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETN,
  input  logic                      HSEL,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [DATA_W-1:0]         HWDATA,
  input  logic                      HREADY,
  output logic [DATA_W-1:0]         HRDATA,
  output logic                      HREADYOUT,
  output logic [1:0]                HRESP,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int FIELD_W = $clog2(NUM_SLV);
  localparam int IDX_W   = (FIELD_W == 0) ? 1 : FIELD_W;
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W:0]   NUM_SLV_L = (IDX_W+1)'(NUM_SLV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN     = (TIMEOUT != 0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   haddr_q;
  logic                hwrite_q;
  logic [2:0]          hsize_q;
  logic [IDX_W-1:0]    idx_q;
  logic                bad_idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    addr_idx;
  logic [STRB_W-1:0]   strb_c;
  logic                start;
  logic                hready_c;
  hresp_e              hresp_c;
  logic                psel_en;
  logic                penable_c;
  logic [DATA_W-1:0]   sel_prdata;
  logic                sel_pready;
  logic                sel_pslverr;
  logic                unused_htrans;

  assign unused_htrans = HTRANS[0];

  // NONSEQ and SEQ both start a transfer; IDLE and BUSY are ignored
  assign start = HSEL & HREADY & HTRANS[1];

  if (FIELD_W == 0) begin : g_one_slv
    assign addr_idx = '0;
  end else begin : g_idx
    assign addr_idx = HADDR[SLV_SEL_LSB +: FIELD_W];
  end

  apb_slave_mux #(
    .NUM_SLV (NUM_SLV),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) u_slave_mux (
    .idx         (idx_q),
    .sel_en      (psel_en),
    .prdata_bus  (PRDATA),
    .pready_bus  (PREADY),
    .pslverr_bus (PSLVERR),
    .psel        (PSEL),
    .prdata      (sel_prdata),
    .pready      (sel_pready),
    .pslverr     (sel_pslverr)
  );

  // Bridge state register
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the state-decoded handshake outputs, so reset clears them at once
  always_comb begin
    state_d   = state_q;
    hready_c  = 1'b1;
    hresp_c   = HRESP_OKAY;
    psel_en   = 1'b0;
    penable_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        hready_c = 1'b0;
        state_d  = (bad_idx_q || (hsize_q > HSIZE_WORD)) ? ST_ERR1 : ST_SETUP;
      end
      ST_SETUP: begin
        hready_c = 1'b0;
        psel_en  = 1'b1;
        state_d  = ST_ACCESS;
      end
      ST_ACCESS: begin
        hready_c  = 1'b0;
        psel_en   = 1'b1;
        penable_c = 1'b1;
        if (sel_pready)                     state_d = sel_pslverr ? ST_ERR1 : ST_DONE;
        else if (TO_EN && cnt_q == CNT_LAST) state_d = ST_ERR1;
      end
      ST_DONE: begin
        state_d = start ? ST_LATCH : ST_IDLE;
      end
      ST_ERR1: begin
        hready_c = 1'b0;
        hresp_c  = HRESP_ERROR;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_c = HRESP_ERROR;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign HREADYOUT = hready_c;
  assign HRESP     = hresp_c;
  assign PENABLE   = penable_c;

  // Byte lanes follow the latched size and low address bits; reads carry no strobes
  always_comb begin
    strb_c = '0;
    if (hwrite_q) begin
      case (hsize_q)
        HSIZE_BYTE: strb_c = STRB_W'(1) << haddr_q[1:0];
        HSIZE_HALF: strb_c = STRB_W'(3) << {haddr_q[1], 1'b0};
        default:    strb_c = '1;
      endcase
    end
  end

  // Address-phase capture, APB request registers and read-data return
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hsize_q   <= '0;
      idx_q     <= '0;
      bad_idx_q <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      HRDATA    <= '0;
    end else begin
      if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
        haddr_q   <= HADDR;
        hwrite_q  <= HWRITE;
        hsize_q   <= HSIZE;
        idx_q     <= addr_idx;
        bad_idx_q <= ({1'b0, addr_idx} >= NUM_SLV_L);
      end
      if (state_q == ST_LATCH) begin
        PADDR  <= haddr_q;
        PWRITE <= hwrite_q;
        PWDATA <= HWDATA;
        PSTRB  <= strb_c;
      end
      if (state_q == ST_ACCESS && sel_pready && !sel_pslverr && !PWRITE) begin
        HRDATA <= sel_prdata;
      end
    end
  end

  // ACCESS-cycle counter for the PREADY timeout; restarts in SETUP and saturates
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ST_ACCESS && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ahb2apb_mux_bridge.sv
// tb/tb_ahb2apb_mux_bridge.sv - scoreboard bench for ahb2apb_mux_bridge
module tb_ahb2apb_mux_bridge;
  import ahb_apb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic        HSEL_a, HSEL_b;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;

  logic [31:0]  HRDATA_a, PADDR_a, PWDATA_a;
  logic         HREADYOUT_a, PENABLE_a, PWRITE_a;
  logic [1:0]   HRESP_a;
  logic [3:0]   PSEL_a, PSTRB_a, PREADY_a, PSLVERR_a;
  logic [127:0] PRDATA_a;

  logic [31:0]  HRDATA_b, PADDR_b, PWDATA_b;
  logic         HREADYOUT_b, PENABLE_b, PWRITE_b;
  logic [1:0]   HRESP_b;
  logic [2:0]   PSEL_b;
  logic [3:0]   PSTRB_b;
  logic [95:0]  PRDATA_b;
  logic [2:0]   PREADY_b, PSLVERR_b;

  logic [31:0] prd [4];
  logic [3:0]  stuck, pslv;
  int unsigned wait_cyc;
  int unsigned acc_cnt = 0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          dut;
    logic [1:0]  resp;
    int          lat;
    logic [3:0]  psel;
    bit          chk_apb;
    logic [31:0] paddr;
    logic [3:0]  pstrb;
    bit          chk_wd;
    logic [31:0] pwdata;
    bit          chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];

  always #5 HCLK = ~HCLK;

  ahb2apb_mux_bridge #(.NUM_SLV(4), .TIMEOUT(16)) dut_a (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL_a), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADYOUT_a),
    .HRDATA(HRDATA_a), .HREADYOUT(HREADYOUT_a), .HRESP(HRESP_a), .PADDR(PADDR_a),
    .PSEL(PSEL_a), .PENABLE(PENABLE_a), .PWRITE(PWRITE_a), .PWDATA(PWDATA_a),
    .PSTRB(PSTRB_a), .PRDATA(PRDATA_a), .PREADY(PREADY_a), .PSLVERR(PSLVERR_a)
  );

  ahb2apb_mux_bridge #(.NUM_SLV(3)) dut_b (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL_b), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADYOUT_b),
    .HRDATA(HRDATA_b), .HREADYOUT(HREADYOUT_b), .HRESP(HRESP_b), .PADDR(PADDR_b),
    .PSEL(PSEL_b), .PENABLE(PENABLE_b), .PWRITE(PWRITE_b), .PWDATA(PWDATA_b),
    .PSTRB(PSTRB_b), .PRDATA(PRDATA_b), .PREADY(PREADY_b), .PSLVERR(PSLVERR_b)
  );

  // APB slave model for DUT A: PREADY after wait_cyc ACCESS cycles unless stuck
  assign PRDATA_a  = {prd[3], prd[2], prd[1], prd[0]};
  assign PSLVERR_a = pslv;
  always_comb begin
    for (int i = 0; i < 4; i++) PREADY_a[i] = !stuck[i] && (acc_cnt >= wait_cyc);
  end
  always @(posedge HCLK) acc_cnt <= PENABLE_a ? acc_cnt + 1 : 0;

  assign PRDATA_b  = {3{32'hB0B0B0B0}};
  assign PREADY_b  = 3'b111;
  assign PSLVERR_b = 3'b000;

  logic        m_rdy   [2];
  logic        m_hsel  [2];
  logic        m_pen   [2];
  logic [1:0]  m_resp  [2];
  logic [31:0] m_rdata [2];
  logic [3:0]  m_psel  [2];
  logic [3:0]  m_pstrb [2];
  logic [31:0] m_paddr [2];
  logic [31:0] m_pwdata[2];
  assign m_rdy[0] = HREADYOUT_a;   assign m_rdy[1] = HREADYOUT_b;
  assign m_hsel[0] = HSEL_a;       assign m_hsel[1] = HSEL_b;
  assign m_pen[0] = PENABLE_a;     assign m_pen[1] = PENABLE_b;
  assign m_resp[0] = HRESP_a;      assign m_resp[1] = HRESP_b;
  assign m_rdata[0] = HRDATA_a;    assign m_rdata[1] = HRDATA_b;
  assign m_psel[0] = PSEL_a;       assign m_psel[1] = {1'b0, PSEL_b};
  assign m_pstrb[0] = PSTRB_a;     assign m_pstrb[1] = PSTRB_b;
  assign m_paddr[0] = PADDR_a;     assign m_paddr[1] = PADDR_b;
  assign m_pwdata[0] = PWDATA_a;   assign m_pwdata[1] = PWDATA_b;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: follows each data phase, pops the expectation when HREADYOUT completes it
  bit          in_ph   [2] = '{0, 0};
  int          lat_m   [2];
  logic [1:0]  prev_rsp[2];
  logic [3:0]  o_psel  [2];
  logic [3:0]  o_pstrb [2];
  logic [31:0] o_paddr [2];
  logic [31:0] o_pwdata[2];

  always @(negedge HCLK) begin : monitor
    exp_t e;
    if (!HRESETN) begin
      in_ph[0] = 0;
      in_ph[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (in_ph[d]) begin
          lat_m[d]++;
          o_psel[d] = o_psel[d] | m_psel[d];
          if (m_pen[d]) begin
            o_paddr[d]  = m_paddr[d];
            o_pstrb[d]  = m_pstrb[d];
            o_pwdata[d] = m_pwdata[d];
          end
          if (m_rdy[d]) begin
            in_ph[d] = 0;
            if (sbq.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL sb_unexpected: dut %0d completed with no expectation", d);
            end else begin
              e = sbq.pop_front();
              cmp("dut_id", d, e.dut);
              cmp("hresp_last", {30'd0, m_resp[d]}, {30'd0, e.resp});
              cmp("hresp_prev", {30'd0, prev_rsp[d]}, {30'd0, e.resp});
              cmp("latency", lat_m[d], e.lat);
              cmp("psel", {28'd0, o_psel[d]}, {28'd0, e.psel});
              if (e.chk_apb) begin
                cmp("paddr", o_paddr[d], e.paddr);
                cmp("pstrb", {28'd0, o_pstrb[d]}, {28'd0, e.pstrb});
              end
              if (e.chk_wd) cmp("pwdata", o_pwdata[d], e.pwdata);
              if (e.chk_rd) cmp("hrdata", m_rdata[d], e.rdata);
            end
          end else begin
            prev_rsp[d] = m_resp[d];
          end
        end
        if (m_hsel[d] && m_rdy[d] && HTRANS[1]) begin
          in_ph[d]    = 1;
          lat_m[d]    = 0;
          o_psel[d]   = '0;
          o_pstrb[d]  = '0;
          o_paddr[d]  = '0;
          o_pwdata[d] = '0;
        end
      end
    end
  end

  task automatic push(input int d, input logic [1:0] resp, input int lat, input logic [3:0] psel,
                      input bit chk_apb, input logic [31:0] paddr, input logic [3:0] pstrb,
                      input bit chk_wd, input logic [31:0] wd, input bit chk_rd, input logic [31:0] rd);
    exp_t e;
    e.dut = d; e.resp = resp; e.lat = lat; e.psel = psel;
    e.chk_apb = chk_apb; e.paddr = paddr; e.pstrb = pstrb;
    e.chk_wd = chk_wd; e.pwdata = wd; e.chk_rd = chk_rd; e.rdata = rd;
    sbq.push_back(e);
  endtask

  task automatic addr_phase(input int d, input logic [31:0] a, input bit wr, input logic [2:0] sz);
    HSEL_a = (d == 0);
    HSEL_b = (d == 1);
    HADDR  = a;
    HTRANS = HTRANS_NONSEQ;
    HWRITE = wr;
    HSIZE  = sz;
  endtask

  task automatic idle_bus();
    HSEL_a = 1'b0;
    HSEL_b = 1'b0;
    HTRANS = HTRANS_IDLE;
  endtask

  task automatic wait_done(input int d);
    int  k;
    bit  rdy;
    k = 0;
    do begin
      @(negedge HCLK);
      rdy = (d == 0) ? HREADYOUT_a : HREADYOUT_b;
      k++;
    end while (!rdy && k < 100);
    if (!rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: dut %0d HREADYOUT stayed 0 for %0d cycles, required 1", d, k);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic xfer(input int d, input logic [31:0] a, input bit wr, input logic [2:0] sz,
                      input logic [31:0] wd);
    addr_phase(d, a, wr, sz);
    @(posedge HCLK);
    #1;
    idle_bus();
    HWDATA = wd;
    wait_done(d);
  endtask

  task automatic chk_reset(input string tag);
    cmp({tag, "_hreadyout"}, {31'd0, HREADYOUT_a}, 32'd1);
    cmp({tag, "_hresp"},     {30'd0, HRESP_a}, 32'd0);
    cmp({tag, "_hrdata"},    HRDATA_a, 32'd0);
    cmp({tag, "_psel"},      {28'd0, PSEL_a}, 32'd0);
    cmp({tag, "_penable"},   {31'd0, PENABLE_a}, 32'd0);
    cmp({tag, "_pwrite"},    {31'd0, PWRITE_a}, 32'd0);
    cmp({tag, "_paddr"},     PADDR_a, 32'd0);
    cmp({tag, "_pwdata"},    PWDATA_a, 32'd0);
    cmp({tag, "_pstrb"},     {28'd0, PSTRB_a}, 32'd0);
    cmp({tag, "_b_psel"},    {29'd0, PSEL_b}, 32'd0);
  endtask

  logic [31:0] sv_addr [5] = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0003, 32'h0000_1000, 32'h0000_2001};
  logic [2:0]  sv_size [5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
  logic [31:0] sv_wd   [5] = '{32'h00AB_0000, 32'h1234_0000, 32'hEE00_0000, 32'h0000_BEEF, 32'h0000_CD00};
  logic [3:0]  sv_strb [5] = '{4'b0100, 4'b1100, 4'b1000, 4'b0011, 4'b0010};
  logic [3:0]  sv_psel [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    HRESETN = 1'b0;
    idle_bus();
    HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2; HWDATA = '0;
    stuck = 4'b0000; pslv = 4'b0000; wait_cyc = 0;
    prd[0] = 32'hBAD0_0000; prd[1] = 32'hCAFE_0001; prd[2] = 32'hBAD0_0002; prd[3] = 32'h1234_5678;
    repeat (2) @(posedge HCLK);
    #1;
    chk_reset("rst");
    HRESETN = 1'b1;
    @(posedge HCLK);
    #1;

    // BUSY and IDLE with HSEL high start nothing
    HSEL_a = 1'b1; HADDR = 32'h0000_1000; HTRANS = HTRANS_BUSY;
    @(posedge HCLK); #1;
    HTRANS = HTRANS_IDLE;
    @(posedge HCLK); #1;
    cmp("busy_idle_hreadyout", {31'd0, HREADYOUT_a}, 32'd1);
    cmp("busy_idle_psel", {28'd0, PSEL_a}, 32'd0);
    idle_bus();

    // Word write to slave 1, zero wait
    push(0, 2'b00, 4, 4'b0010, 1, 32'h0000_1004, 4'b1111, 1, 32'hDEAD_BEEF, 0, 32'h0);
    xfer(0, 32'h0000_1004, 1'b1, 3'd2, 32'hDEAD_BEEF);

    // Read slave 3 with two wait states
    wait_cyc = 2;
    push(0, 2'b00, 6, 4'b1000, 1, 32'h0000_3000, 4'b0000, 0, 32'h0, 1, 32'h1234_5678);
    xfer(0, 32'h0000_3000, 1'b0, 3'd2, 32'h0);
    wait_cyc = 0;

    // Sub-word write strobes
    for (int i = 0; i < 5; i++) begin
      push(0, 2'b00, 4, sv_psel[i], 1, sv_addr[i], sv_strb[i], 1, sv_wd[i], 0, 32'h0);
      xfer(0, sv_addr[i], 1'b1, sv_size[i], sv_wd[i]);
    end

    // Decode error on the three-slave bridge, then a good read there
    push(1, 2'b01, 3, 4'b0000, 0, 32'h0, 4'b0, 0, 32'h0, 0, 32'h0);
    xfer(1, 32'h0000_3000, 1'b0, 3'd2, 32'h0);
    push(1, 2'b00, 4, 4'b0100, 1, 32'h0000_2000, 4'b0000, 0, 32'h0, 1, 32'hB0B0_B0B0);
    xfer(1, 32'h0000_2000, 1'b0, 3'd2, 32'h0);

    // Size error
    push(0, 2'b01, 3, 4'b0000, 0, 32'h0, 4'b0, 0, 32'h0, 0, 32'h0);
    xfer(0, 32'h0000_1000, 1'b1, 3'd3, 32'h1111_1111);

    // PSLVERR on slave 0 read: error pair, HRDATA keeps the last good read
    pslv = 4'b0001;
    push(0, 2'b01, 5, 4'b0001, 1, 32'h0000_0010, 4'b0000, 0, 32'h0, 1, 32'h1234_5678);
    xfer(0, 32'h0000_0010, 1'b0, 3'd2, 32'h0);
    pslv = 4'b0000;

    // PREADY stuck on slave 2: 16 ACCESS cycles then error
    stuck = 4'b0100;
    push(0, 2'b01, 20, 4'b0100, 1, 32'h0000_2000, 4'b0000, 0, 32'h0, 1, 32'h1234_5678);
    xfer(0, 32'h0000_2000, 1'b0, 3'd2, 32'h0);
    stuck = 4'b0000;

    // Back-to-back write then read on slave 1, unselected slaves flag errors
    pslv = 4'b1101;
    push(0, 2'b00, 4, 4'b0010, 1, 32'h0000_1008, 4'b1111, 1, 32'hA5A5_A5A5, 0, 32'h0);
    push(0, 2'b00, 4, 4'b0010, 1, 32'h0000_100C, 4'b0000, 0, 32'h0, 1, 32'hCAFE_0001);
    addr_phase(0, 32'h0000_1008, 1'b1, 3'd2);
    @(posedge HCLK); #1;
    idle_bus();
    HWDATA = 32'hA5A5_A5A5;
    repeat (3) @(posedge HCLK);
    #1;
    addr_phase(0, 32'h0000_100C, 1'b0, 3'd2);
    @(posedge HCLK); #1;
    idle_bus();
    HWDATA = 32'h0;
    wait_done(0);
    pslv = 4'b0000;

    // Asynchronous reset during ACCESS
    stuck = 4'b0100;
    addr_phase(0, 32'h0000_2000, 1'b0, 3'd2);
    @(posedge HCLK); #1;
    idle_bus();
    repeat (2) @(posedge HCLK);
    #1;
    cmp("pre_rst_penable", {31'd0, PENABLE_a}, 32'd1);
    cmp("pre_rst_psel", {28'd0, PSEL_a}, 32'd4);
    #2;
    HRESETN = 1'b0;
    #1;
    chk_reset("async_rst");
    stuck = 4'b0000;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETN = 1'b1;
    @(posedge HCLK); #1;

    // Clean traffic after reset
    push(0, 2'b00, 4, 4'b1000, 1, 32'h0000_3010, 4'b1111, 1, 32'h55AA_55AA, 0, 32'h0);
    xfer(0, 32'h0000_3010, 1'b1, 3'd2, 32'h55AA_55AA);
    push(0, 2'b00, 4, 4'b1000, 1, 32'h0000_3010, 4'b0000, 0, 32'h0, 1, 32'h1234_5678);
    xfer(0, 32'h0000_3010, 1'b0, 3'd2, 32'h0);

    repeat (3) @(posedge HCLK);
    #1;
    cmp("sb_drain", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
